branch_target_predictor: RTL and testbench
==========================================

Name: branch_target_predictor

Overview:
Parametrised dynamic branch predictor for the pipelined RV32I core. It replaces the fixed backward-taken/forward-not-taken decision used at DECODE with a direct-mapped branch target buffer (BTB) of saturating counters, falling back to static BTFNT on a miss. DECODE performs a zero-latency lookup; EXECUTE sends resolved outcomes back as updates. It also keeps saturating lookup and mispredict statistics counters.

Parameters:
ENTRIES, 16, BTB entries; power of two, 2..256; IDX_BITS = log2(ENTRIES)
COUNTER_BITS, 2, saturating counter width, 1..4
PC_WIDTH, 32, PC/target width; TAG_BITS = PC_WIDTH-IDX_BITS-2
FALLBACK_BTFNT, 1, 1 = on miss predict taken when lookup_backward; 0 = miss always not-taken
STAT_WIDTH, 16, width of statistics counters

Ports:
clk  input  1  core clock
reset  input  1  asynchronous, active-low reset
lookup_valid  input  1  DECODE holds a branch/jump needing prediction
lookup_pc  input  PC_WIDTH  PC of instruction in DECODE
lookup_backward  input  1  decoded immediate sign bit (branch offset negative)
lookup_static_target  input  PC_WIDTH  decoded pc+imm target for fallback
predict_hit  output  1  BTB tag hit
predict_taken  output  1  redirect fetch
predict_target  output  PC_WIDTH  redirect address, bit 0 forced 0
update_valid  input  1  EXECUTE resolved a branch/jump this cycle
update_pc  input  PC_WIDTH  PC of resolved instruction
update_is_jump  input  1  JAL/JALR (unconditional)
update_taken  input  1  actual outcome
update_target  input  PC_WIDTH  actual target
update_mispredict  input  1  EXECUTE detected a mispredict, flushing
flush_all  input  1  invalidate every entry (fence/context change)
lookup_count  output  STAT_WIDTH  lookups with lookup_valid=1
mispredict_count  output  STAT_WIDTH  updates with update_mispredict=1

Behaviour:
- Index = pc[IDX_BITS+1:2]; tag = pc[PC_WIDTH-1:IDX_BITS+2]. Each entry holds valid, tag, target, is_jump, counter.
- Lookup is combinational from registered state (0 cycles). hit = lookup_valid & valid[idx] & tag match.
- Hit: predict_taken = is_jump | counter MSB; predict_target = stored target.
- Miss: predict_taken = FALLBACK_BTFNT & lookup_backward; predict_target = lookup_static_target.
- lookup_valid=0: predict_hit=0, predict_taken=0, predict_target=0.
- Update writes at posedge when update_valid=1:
  - Hit: counter +1 if taken, -1 if not, saturating at 0 and 2^COUNTER_BITS-1. Target is overwritten only when taken. is_jump is updated.
  - Miss and (taken or is_jump): allocate (overwrite) the entry. valid=1, tag, target, is_jump, counter = 2^(COUNTER_BITS-1) (weakly taken). A jump sets the counter to max.
  - Miss and not taken, not a jump: no allocation, table unchanged.
- Same-cycle lookup and update at the same index: the lookup sees the pre-update contents (no bypass). The new value is visible the next cycle.
- flush_all: all valid bits clear at the next edge. Counters and targets are untouched. If update_valid is also high that cycle, flush wins and no allocation occurs. Statistics are not cleared.
- Statistics: lookup_count increments on each cycle with lookup_valid=1; mispredict_count increments on update_valid & update_mispredict. Both saturate at all-ones and never wrap.
- Async reset (reset=0): all valid=0, counters = 2^(COUNTER_BITS-1)-1 (weakly not-taken), targets/tags=0, both stats=0. Outputs are combinational from state, so predict_* = 0 unless lookup_valid=1. Reset mid-update discards the update. Release is synchronous to clk (deassertion synchronised in the top level).
- No stall/ready handshake: one lookup and one update are accepted every cycle.

Test Plan:
- Reset, lookup pc=0x100, backward=1, static_target=0xF0 -> hit=0, taken=1, target=0xF0. With FALLBACK_BTFNT=0 -> taken=0.
- Update pc=0x100, taken=1, target=0x80; next cycle lookup 0x100 -> hit=1, taken=1, target=0x80 (counter=2). Two not-taken updates -> counter 0, taken=0. A third not-taken update keeps the counter at 0.
- Aliasing, ENTRIES=16: allocate 0x100, then update taken for 0x140 (same index, different tag) -> lookup 0x100 misses, lookup 0x140 hits.
- Same cycle: update 0x200 taken (allocate) while looking up 0x200 -> hit=0 that cycle, hit=1 next cycle. JAL update at 0x300 -> taken=1 with counter at max.
- flush_all asserted with an update to 0x400 -> next cycle every lookup misses, including 0x400. lookup_count retains its value.
- STAT_WIDTH=4: 20 cycles of lookup_valid -> lookup_count=15. Assert reset mid-run -> stats 0 and all entries invalid immediately, without a clock edge.

Source files
------------

// File: rtl/branch_target_predictor_if.sv
// DECODE/EXECUTE side bundle for the branch predictor: lookup request, prediction, resolved update, stats.
// master drives lookups/updates; slave is the predictor.
interface branch_target_predictor_if #(
    parameter int PC_WIDTH   = 32,
    parameter int STAT_WIDTH = 16
);
    logic                  lookup_valid;
    logic [PC_WIDTH-1:0]   lookup_pc;
    logic                  lookup_backward;
    logic [PC_WIDTH-1:0]   lookup_static_target;
    logic                  predict_hit;
    logic                  predict_taken;
    logic [PC_WIDTH-1:0]   predict_target;
    logic                  update_valid;
    logic [PC_WIDTH-1:0]   update_pc;
    logic                  update_is_jump;
    logic                  update_taken;
    logic [PC_WIDTH-1:0]   update_target;
    logic                  update_mispredict;
    logic                  flush_all;
    logic [STAT_WIDTH-1:0] lookup_count;
    logic [STAT_WIDTH-1:0] mispredict_count;

    modport master (
        output lookup_valid, lookup_pc, lookup_backward, lookup_static_target,
        output update_valid, update_pc, update_is_jump, update_taken, update_target,
        output update_mispredict, flush_all,
        input  predict_hit, predict_taken, predict_target, lookup_count, mispredict_count
    );

    modport slave (
        input  lookup_valid, lookup_pc, lookup_backward, lookup_static_target,
        input  update_valid, update_pc, update_is_jump, update_taken, update_target,
        input  update_mispredict, flush_all,
        output predict_hit, predict_taken, predict_target, lookup_count, mispredict_count
    );
endinterface

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB predictor with saturating counters, static BTFNT fallback on miss, and saturating stats.
// Lookup is 0-cycle combinational, updates land at the next edge; no backpressure, one lookup + one update per cycle.
module branch_target_predictor #(
    parameter int ENTRIES        = 16,
    parameter int COUNTER_BITS   = 2,
    parameter int PC_WIDTH       = 32,
    parameter int FALLBACK_BTFNT = 1,
    parameter int STAT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    branch_target_predictor_if.slave bus
);
    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam int TAG_BITS = PC_WIDTH - IDX_BITS - 2;
    localparam logic [COUNTER_BITS-1:0] CTR_MAX     = '1;
    localparam logic [COUNTER_BITS-1:0] CTR_WEAK_NT = CTR_MAX >> 1;
    localparam logic [COUNTER_BITS-1:0] CTR_WEAK_T  = CTR_MAX ^ (CTR_MAX >> 1);
    localparam logic [STAT_WIDTH-1:0]   STAT_MAX    = '1;

    // Assertion is immediate; release is retimed to clk through two flops.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    logic                    ent_valid  [ENTRIES];
    logic [TAG_BITS-1:0]     ent_tag    [ENTRIES];
    logic [PC_WIDTH-1:0]     ent_target [ENTRIES];
    logic                    ent_jump   [ENTRIES];
    logic [COUNTER_BITS-1:0] ent_ctr    [ENTRIES];

    logic [IDX_BITS-1:0] l_idx, u_idx;
    logic [TAG_BITS-1:0] l_tag, u_tag;
    logic                l_hit, u_hit;
    logic [PC_WIDTH-1:0] raw_target;
    logic                raw_taken;
    logic [COUNTER_BITS-1:0] ctr_next;

    assign l_idx = bus.lookup_pc[IDX_BITS+1:2];
    assign l_tag = bus.lookup_pc[PC_WIDTH-1:IDX_BITS+2];
    assign u_idx = bus.update_pc[IDX_BITS+1:2];
    assign u_tag = bus.update_pc[PC_WIDTH-1:IDX_BITS+2];

    assign l_hit = bus.lookup_valid && ent_valid[l_idx] && (ent_tag[l_idx] == l_tag);
    assign u_hit = ent_valid[u_idx] && (ent_tag[u_idx] == u_tag);

    always_comb begin
        raw_taken  = 1'b0;
        raw_target = '0;
        if (bus.lookup_valid) begin
            if (l_hit) begin
                raw_taken  = ent_jump[l_idx] || ent_ctr[l_idx][COUNTER_BITS-1];
                raw_target = ent_target[l_idx];
            end else begin
                raw_taken  = (FALLBACK_BTFNT != 0) && bus.lookup_backward;
                raw_target = bus.lookup_static_target;
            end
        end
    end

    assign bus.predict_hit    = l_hit;
    assign bus.predict_taken  = raw_taken;
    assign bus.predict_target = {raw_target[PC_WIDTH-1:1], 1'b0};

    always_comb begin
        ctr_next = ent_ctr[u_idx];
        if (bus.update_taken && ent_ctr[u_idx] != CTR_MAX)
            ctr_next = ent_ctr[u_idx] + COUNTER_BITS'(1);
        else if (!bus.update_taken && ent_ctr[u_idx] != '0)
            ctr_next = ent_ctr[u_idx] - COUNTER_BITS'(1);
    end

    // Flush pre-empts any same-cycle update, so nothing is allocated into a table being invalidated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ent_valid[i]  <= 1'b0;
                ent_tag[i]    <= '0;
                ent_target[i] <= '0;
                ent_jump[i]   <= 1'b0;
                ent_ctr[i]    <= CTR_WEAK_NT;
            end
        end else if (bus.flush_all) begin
            for (int i = 0; i < ENTRIES; i++) ent_valid[i] <= 1'b0;
        end else if (bus.update_valid) begin
            if (u_hit) begin
                ent_ctr[u_idx]  <= ctr_next;
                ent_jump[u_idx] <= bus.update_is_jump;
                if (bus.update_taken) ent_target[u_idx] <= bus.update_target;
            end else if (bus.update_taken || bus.update_is_jump) begin
                ent_valid[u_idx]  <= 1'b1;
                ent_tag[u_idx]    <= u_tag;
                ent_target[u_idx] <= bus.update_target;
                ent_jump[u_idx]   <= bus.update_is_jump;
                ent_ctr[u_idx]    <= bus.update_is_jump ? CTR_MAX : CTR_WEAK_T;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.lookup_count     <= '0;
            bus.mispredict_count <= '0;
        end else begin
            if (bus.lookup_valid && bus.lookup_count != STAT_MAX)
                bus.lookup_count <= bus.lookup_count + STAT_WIDTH'(1);
            if (bus.update_valid && bus.update_mispredict && bus.mispredict_count != STAT_MAX)
                bus.mispredict_count <= bus.mispredict_count + STAT_WIDTH'(1);
        end
    end

    // Instruction-alignment bits never index the table.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{bus.lookup_pc[1:0], bus.update_pc[1:0], raw_target[0]};
endmodule

// File: tb/tb_branch_target_predictor.sv
// Scoreboarded bench: directed lookup/update vectors with hand-computed predictions, checked by a negedge monitor.
module tb_branch_target_predictor;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    branch_target_predictor_if #(.PC_WIDTH(32), .STAT_WIDTH(8)) bp ();
    branch_target_predictor_if #(.PC_WIDTH(32), .STAT_WIDTH(4)) bp4 ();

    branch_target_predictor #(.ENTRIES(16), .COUNTER_BITS(2), .PC_WIDTH(32),
        .FALLBACK_BTFNT(1), .STAT_WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bp));

    branch_target_predictor #(.ENTRIES(16), .COUNTER_BITS(2), .PC_WIDTH(32),
        .FALLBACK_BTFNT(0), .STAT_WIDTH(4)) dut_nf (.clk(clk), .reset(reset), .bus(bp4));

    assign bp4.lookup_valid         = bp.lookup_valid;
    assign bp4.lookup_pc            = bp.lookup_pc;
    assign bp4.lookup_backward      = bp.lookup_backward;
    assign bp4.lookup_static_target = bp.lookup_static_target;
    assign bp4.update_valid         = bp.update_valid;
    assign bp4.update_pc            = bp.update_pc;
    assign bp4.update_is_jump       = bp.update_is_jump;
    assign bp4.update_taken         = bp.update_taken;
    assign bp4.update_target        = bp.update_target;
    assign bp4.update_mispredict    = bp.update_mispredict;
    assign bp4.flush_all            = bp.flush_all;

    typedef struct packed {
        logic        hit;
        logic        taken;
        logic        taken_nf;
        logic [31:0] target;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_lc = 0, exp_mc = 0, exp_lc4 = 0;
    bit   prev_en = 1'b0, prev_lv = 1'b0, prev_um = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step(input logic rs, input logic lv, input logic [31:0] lpc, input logic bk,
                        input logic [31:0] st, input logic eh, input logic et, input logic [31:0] etg,
                        input logic uv, input logic [31:0] upc, input logic uj, input logic ut,
                        input logic [31:0] utg, input logic um, input logic fl);
        exp_t e;
        @(posedge clk);
        if (prev_en) begin
            if (prev_lv && exp_lc < 255) exp_lc++;
            if (prev_lv && exp_lc4 < 15) exp_lc4++;
            if (prev_um && exp_mc < 255) exp_mc++;
        end
        #1;
        reset                   = rs;
        bp.lookup_valid         = lv;
        bp.lookup_pc            = lpc;
        bp.lookup_backward      = bk;
        bp.lookup_static_target = st;
        bp.update_valid         = uv;
        bp.update_pc            = upc;
        bp.update_is_jump       = uj;
        bp.update_taken         = ut;
        bp.update_target        = utg;
        bp.update_mispredict    = um;
        bp.flush_all            = fl;
        if (!rs) begin
            exp_lc = 0; exp_mc = 0; exp_lc4 = 0;
        end
        prev_en = rs;
        prev_lv = lv;
        prev_um = uv & um;
        if (lv) begin
            e.hit = eh; e.taken = et; e.taken_nf = eh ? et : 1'b0; e.target = etg;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input logic rs);
        step(rs, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: samples mid-cycle, pops an expectation for every presented lookup.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bp.lookup_valid) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'(1), 32'(0));
                end else begin
                    e = sb.pop_front();
                    chk("hit",       32'(bp.predict_hit),    32'(e.hit));
                    chk("taken",     32'(bp.predict_taken),  32'(e.taken));
                    chk("target",    bp.predict_target,      e.target);
                    chk("nf_hit",    32'(bp4.predict_hit),   32'(e.hit));
                    chk("nf_taken",  32'(bp4.predict_taken), 32'(e.taken_nf));
                    chk("nf_target", bp4.predict_target,     e.target);
                end
            end else begin
                chk("idle_hit",    32'(bp.predict_hit),   32'(0));
                chk("idle_taken",  32'(bp.predict_taken), 32'(0));
                chk("idle_target", bp.predict_target,     32'(0));
            end
            chk("lookup_count",     32'(bp.lookup_count),     32'(exp_lc));
            chk("mispredict_count", 32'(bp.mispredict_count), 32'(exp_mc));
            chk("lookup_count4",    32'(bp4.lookup_count),    32'(exp_lc4));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bp.lookup_valid = 0; bp.lookup_pc = 0; bp.lookup_backward = 0; bp.lookup_static_target = 0;
        bp.update_valid = 0; bp.update_pc = 0; bp.update_is_jump = 0; bp.update_taken = 0;
        bp.update_target = 0; bp.update_mispredict = 0; bp.flush_all = 0;

        // Reset: empty table, static fallback only
        idle(0);
        step(0, 1, 'h100, 1, 'hF0,  0, 1, 'hF0,   0, 0, 0, 0, 0, 0, 0);
        idle(1); idle(1); idle(1);

        // Allocate 0x100, then walk its counter 2 -> 1 -> 0 -> 0 -> 1
        step(1, 1, 'h100, 1, 'hF0,  0, 1, 'hF0,   1, 'h100, 0, 1, 'h80,  0, 0);
        step(1, 1, 'h100, 0, 'h104, 1, 1, 'h80,   1, 'h100, 0, 0, 'h104, 0, 0);
        step(1, 1, 'h100, 0, 'h104, 1, 0, 'h80,   1, 'h100, 0, 0, 'h104, 1, 0);
        step(1, 1, 'h100, 0, 'h104, 1, 0, 'h80,   1, 'h100, 0, 0, 'h104, 0, 0);
        step(1, 1, 'h100, 0, 'h104, 1, 0, 'h80,   1, 'h100, 0, 1, 'h84,  0, 0);
        step(1, 1, 'h100, 0, 'h104, 1, 0, 'h84,   0, 0, 0, 0, 0, 0, 0);

        // Alias 0x140 onto index 0 evicts 0x100
        step(1, 0, 0, 0, 0,         0, 0, 0,      1, 'h140, 0, 1, 'h40,  0, 0);
        step(1, 1, 'h100, 0, 'h104, 0, 0, 'h104,  0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 'h140, 0, 'h1000,1, 1, 'h40,   0, 0, 0, 0, 0, 0, 0);

        // Same-cycle lookup sees pre-update state
        step(1, 1, 'h200, 0, 'h300, 0, 0, 'h300,  1, 'h200, 0, 1, 'h280, 0, 0);
        step(1, 1, 'h200, 0, 'h300, 1, 1, 'h280,  0, 0, 0, 0, 0, 0, 0);

        // JAL allocates at counter max; one not-taken update still leaves it taken
        step(1, 0, 0, 0, 0,         0, 0, 0,      1, 'h300, 1, 1, 'h1235, 1, 0);
        step(1, 1, 'h300, 0, 'h304, 1, 1, 'h1234, 1, 'h300, 0, 0, 'h304, 1, 0);
        step(1, 1, 'h300, 0, 'h304, 1, 1, 'h1234, 0, 0, 0, 0, 0, 0, 0);

        // Flush wins over a same-cycle allocation
        step(1, 0, 0, 0, 0,         0, 0, 0,      1, 'h400, 0, 1, 'h480, 0, 1);
        step(1, 1, 'h400, 0, 'h500, 0, 0, 'h500,  0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 'h100, 1, 'hC0,  0, 1, 'hC0,   0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 'h200, 0, 'h300, 0, 0, 'h300,  0, 0, 0, 0, 0, 0, 0);

        // Drive the 4-bit lookup counter into saturation
        for (int i = 0; i < 20; i++)
            step(1, 1, 'h600, 0, 'h604, 0, 0, 'h604, 0, 0, 0, 0, 0, 0, 0);

        // Mid-run reset: entries and stats clear immediately, pending update is dropped
        step(1, 0, 0, 0, 0,         0, 0, 0,      1, 'h700, 0, 1, 'h780, 0, 0);
        step(1, 1, 'h700, 0, 'h704, 1, 1, 'h780,  0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 'h700, 0, 'h704, 0, 0, 'h704,  1, 'h800, 0, 1, 'h880, 0, 0);
        idle(1); idle(1); idle(1);
        step(1, 1, 'h800, 0, 'h900, 0, 0, 'h900,  0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 'h700, 1, 'h6F0, 0, 1, 'h6F0,  0, 0, 0, 0, 0, 0, 0);
        idle(1);

        @(negedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
